// File: rtl/noc_pkg.sv
// Shared flit format and helpers for the NoC local endpoint.
// A flit carries the core payload above the router's routing field {x, y}.
package noc_pkg;

  localparam int FLIT_W = 16;

  typedef struct packed {
    logic [7:0] payload;
    logic [3:0] x;
    logic [3:0] y;
  } flit_t;

  function automatic logic [7:0] dest_of(input flit_t f);
    return {f.x, f.y};
  endfunction

endpackage

// File: rtl/noc_local_endpoint_if.sv
// Bundle of core-side and router-side signals of the local endpoint.
// master = the core/router environment, slave = the endpoint itself.
interface noc_local_endpoint_if #(
  parameter int TX_CREDITS = 4
);
  localparam int CNT_W = $clog2(TX_CREDITS + 1);

  logic [7:0]                 tx_payload_i;
  logic [7:0]                 tx_dest_i;
  logic                       tx_valid_i;
  logic                       tx_ready_o;
  logic [noc_pkg::FLIT_W-1:0] net_data_o;
  logic                       net_enable_o;
  logic                       net_credit_i;
  logic [noc_pkg::FLIT_W-1:0] net_data_i;
  logic                       net_enable_i;
  logic                       net_credit_o;
  logic [noc_pkg::FLIT_W-1:0] rx_data_o;
  logic                       rx_valid_o;
  logic                       rx_pop_i;
  logic [CNT_W-1:0]           credit_cnt_o;
  logic                       rx_overflow_o;
  logic                       credit_err_o;
  logic [15:0]                tx_count_o;
  logic [15:0]                rx_count_o;
  logic [7:0]                 node_id_o;

  modport master (
    output tx_payload_i, tx_dest_i, tx_valid_i, net_credit_i,
           net_data_i, net_enable_i, rx_pop_i,
    input  tx_ready_o, net_data_o, net_enable_o, net_credit_o,
           rx_data_o, rx_valid_o, credit_cnt_o, rx_overflow_o,
           credit_err_o, tx_count_o, rx_count_o, node_id_o
  );

  modport slave (
    input  tx_payload_i, tx_dest_i, tx_valid_i, net_credit_i,
           net_data_i, net_enable_i, rx_pop_i,
    output tx_ready_o, net_data_o, net_enable_o, net_credit_o,
           rx_data_o, rx_valid_o, credit_cnt_o, rx_overflow_o,
           credit_err_o, tx_count_o, rx_count_o, node_id_o
  );

endinterface

// File: rtl/noc_ep_rx_fifo.sv
// First-word fall-through RX FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB; a pop frees a slot for a push in the same cycle.
module noc_ep_rx_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = noc_pkg::flit_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full,
  output logic drop
);
  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: only the pointers are reset; storage needs no reset because
  // nothing is ever read from a slot that was not written since reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_local_endpoint.sv
// Local-port endpoint: credit-controlled flit injection towards the router and
// an RX FIFO whose pops are returned to the router as credits.
module noc_local_endpoint
  import noc_pkg::*;
#(
  parameter logic [3:0] XCOORD     = 4'd0,
  parameter logic [3:0] YCOORD     = 4'd0,
  parameter int         TX_CREDITS = 4,
  parameter int         RX_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_local_endpoint_if.slave  bus
);
  localparam int               CNT_W    = $clog2(TX_CREDITS + 1);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(TX_CREDITS);

  logic [CNT_W-1:0] credits;
  logic             credit_err;
  flit_t            net_data;
  logic             net_enable;
  logic             net_credit;
  logic [15:0]      tx_count;
  logic [15:0]      rx_count;
  logic             rx_overflow;

  flit_t            tx_flit;
  flit_t            rx_head;
  logic             tx_fire;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_drop;
  logic             rx_pop_ok;

  assign tx_flit   = '{payload: bus.tx_payload_i, x: bus.tx_dest_i[7:4], y: bus.tx_dest_i[3:0]};
  assign tx_fire   = bus.tx_valid_i && (credits != '0);
  assign rx_pop_ok = bus.rx_pop_i && !rx_empty;

  noc_ep_rx_fifo #(.DEPTH(RX_DEPTH), .T(flit_t)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.net_enable_i),
    .push_data (flit_t'(bus.net_data_i)),
    .pop       (bus.rx_pop_i),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full),
    .drop      (rx_drop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits     <= CRED_MAX;
      credit_err  <= 1'b0;
      net_data    <= '0;
      net_enable  <= 1'b0;
      net_credit  <= 1'b0;
      tx_count    <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      net_enable <= tx_fire;
      if (tx_fire) begin
        net_data <= tx_flit;
        tx_count <= tx_count + 16'd1;
      end
      // A send and a returned credit in the same cycle cancel out.
      unique case ({tx_fire, bus.net_credit_i})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01: begin
          if (credits == CRED_MAX) credit_err <= 1'b1;
          else                     credits    <= credits + CNT_W'(1);
        end
        default: ;
      endcase
      net_credit <= rx_pop_ok;
      if (rx_pop_ok) rx_count <= rx_count + 16'd1;
      if (rx_drop)   rx_overflow <= 1'b1;
    end
  end

  assign bus.tx_ready_o    = (credits != '0);
  assign bus.net_data_o    = net_data;
  assign bus.net_enable_o  = net_enable;
  assign bus.net_credit_o  = net_credit;
  assign bus.rx_data_o     = rx_head;
  assign bus.rx_valid_o    = !rx_empty;
  assign bus.credit_cnt_o  = credits;
  assign bus.rx_overflow_o = rx_overflow;
  assign bus.credit_err_o  = credit_err;
  assign bus.tx_count_o    = tx_count;
  assign bus.rx_count_o    = rx_count;
  assign bus.node_id_o     = {XCOORD, YCOORD};

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Directed bench for noc_local_endpoint: credit flow, RX FIFO ordering,
// overflow/credit-error flags and asynchronous reset mid-operation.
module tb_noc_local_endpoint;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  noc_local_endpoint_if #(.TX_CREDITS(4)) bus ();

  noc_local_endpoint #(
    .XCOORD(4'd3), .YCOORD(4'd5), .TX_CREDITS(4), .RX_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tx_valid_i   = 1'b0;
    bus.tx_payload_i = 8'h00;
    bus.tx_dest_i    = 8'h00;
    bus.net_credit_i = 1'b0;
    bus.net_data_i   = 16'h0000;
    bus.net_enable_i = 1'b0;
    bus.rx_pop_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.credit_cnt_o !== 3'd4)    begin n_err++; $display("FAIL reset_credits got %0d want 4", bus.credit_cnt_o); end
    n_cmp++; if (bus.tx_ready_o !== 1'b1)      begin n_err++; $display("FAIL reset_ready got %b want 1", bus.tx_ready_o); end
    n_cmp++; if (bus.net_enable_o !== 1'b0)    begin n_err++; $display("FAIL reset_net_enable got %b want 0", bus.net_enable_o); end
    n_cmp++; if (bus.net_data_o !== 16'h0000)  begin n_err++; $display("FAIL reset_net_data got %h want 0000", bus.net_data_o); end
    n_cmp++; if (bus.net_credit_o !== 1'b0)    begin n_err++; $display("FAIL reset_net_credit got %b want 0", bus.net_credit_o); end
    n_cmp++; if (bus.rx_valid_o !== 1'b0)      begin n_err++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid_o); end
    n_cmp++; if (bus.rx_overflow_o !== 1'b0 || bus.credit_err_o !== 1'b0)
      begin n_err++; $display("FAIL reset_flags got ovf=%b cerr=%b want 0/0", bus.rx_overflow_o, bus.credit_err_o); end
    n_cmp++; if (bus.tx_count_o !== 16'd0 || bus.rx_count_o !== 16'd0)
      begin n_err++; $display("FAIL reset_counts got tx=%0d rx=%0d want 0/0", bus.tx_count_o, bus.rx_count_o); end
    n_cmp++; if (bus.node_id_o !== 8'h35)      begin n_err++; $display("FAIL node_id got %h want 35", bus.node_id_o); end
  endtask

  task automatic test_tx_burst();
    logic [7:0]  pl;
    logic [2:0]  exp_cnt;
    logic        exp_rdy;
    for (int i = 0; i < 5; i++) begin
      pl      = 8'h11 + 8'(i);
      exp_rdy = (i < 4);
      exp_cnt = (i < 4) ? 3'(3 - i) : 3'd0;
      bus.tx_valid_i   = 1'b1;
      bus.tx_payload_i = pl;
      bus.tx_dest_i    = 8'h21;
      #1;
      n_cmp++; if (bus.tx_ready_o !== exp_rdy) begin n_err++; $display("FAIL burst_ready[%0d] got %b want %b", i, bus.tx_ready_o, exp_rdy); end
      tick();
      n_cmp++; if (bus.net_enable_o !== exp_rdy) begin n_err++; $display("FAIL burst_enable[%0d] got %b want %b", i, bus.net_enable_o, exp_rdy); end
      if (exp_rdy) begin
        n_cmp++; if (bus.net_data_o !== {pl, 8'h21}) begin n_err++; $display("FAIL burst_data[%0d] got %h want %h", i, bus.net_data_o, {pl, 8'h21}); end
      end
      n_cmp++; if (bus.credit_cnt_o !== exp_cnt) begin n_err++; $display("FAIL burst_credits[%0d] got %0d want %0d", i, bus.credit_cnt_o, exp_cnt); end
    end
    bus.tx_valid_i = 1'b0;
    tick();
    n_cmp++; if (bus.net_enable_o !== 1'b0)   begin n_err++; $display("FAIL burst_idle_enable got %b want 0", bus.net_enable_o); end
    n_cmp++; if (bus.net_data_o !== 16'h1421) begin n_err++; $display("FAIL burst_hold_data got %h want 1421", bus.net_data_o); end
    n_cmp++; if (bus.tx_count_o !== 16'd4)    begin n_err++; $display("FAIL burst_tx_count got %0d want 4", bus.tx_count_o); end
    n_cmp++; if (bus.tx_ready_o !== 1'b0)     begin n_err++; $display("FAIL burst_ready_low got %b want 0", bus.tx_ready_o); end
  endtask

  task automatic test_credit_return();
    bus.net_credit_i = 1'b1;
    tick();
    bus.net_credit_i = 1'b0;
    #1;
    n_cmp++; if (bus.credit_cnt_o !== 3'd1) begin n_err++; $display("FAIL ret_credits got %0d want 1", bus.credit_cnt_o); end
    n_cmp++; if (bus.tx_ready_o !== 1'b1)   begin n_err++; $display("FAIL ret_ready got %b want 1", bus.tx_ready_o); end
    bus.tx_valid_i   = 1'b1;
    bus.tx_payload_i = 8'h15;
    bus.tx_dest_i    = 8'h21;
    tick();
    bus.tx_valid_i = 1'b0;
    n_cmp++; if (bus.net_enable_o !== 1'b1 || bus.net_data_o !== 16'h1521)
      begin n_err++; $display("FAIL ret_flit got en=%b data=%h want 1/1521", bus.net_enable_o, bus.net_data_o); end
    n_cmp++; if (bus.credit_cnt_o !== 3'd0) begin n_err++; $display("FAIL ret_credits_zero got %0d want 0", bus.credit_cnt_o); end
    n_cmp++; if (bus.tx_count_o !== 16'd5)  begin n_err++; $display("FAIL ret_tx_count got %0d want 5", bus.tx_count_o); end
    tick();
    n_cmp++; if (bus.net_enable_o !== 1'b0) begin n_err++; $display("FAIL ret_single_pulse got %b want 0", bus.net_enable_o); end
  endtask

  task automatic test_credit_corner();
    bus.net_credit_i = 1'b1;
    tick();
    tick();
    bus.net_credit_i = 1'b0;
    n_cmp++; if (bus.credit_cnt_o !== 3'd2) begin n_err++; $display("FAIL corner_two got %0d want 2", bus.credit_cnt_o); end
    bus.net_credit_i = 1'b1;
    bus.tx_valid_i   = 1'b1;
    bus.tx_payload_i = 8'h16;
    bus.tx_dest_i    = 8'h21;
    tick();
    idle_inputs();
    n_cmp++; if (bus.credit_cnt_o !== 3'd2) begin n_err++; $display("FAIL corner_cancel got %0d want 2", bus.credit_cnt_o); end
    n_cmp++; if (bus.net_enable_o !== 1'b1 || bus.net_data_o !== 16'h1621)
      begin n_err++; $display("FAIL corner_flit got en=%b data=%h want 1/1621", bus.net_enable_o, bus.net_data_o); end
    n_cmp++; if (bus.tx_count_o !== 16'd6)  begin n_err++; $display("FAIL corner_tx_count got %0d want 6", bus.tx_count_o); end
    bus.net_credit_i = 1'b1;
    tick();
    tick();
    bus.net_credit_i = 1'b0;
    n_cmp++; if (bus.credit_cnt_o !== 3'd4 || bus.credit_err_o !== 1'b0)
      begin n_err++; $display("FAIL corner_full got cnt=%0d err=%b want 4/0", bus.credit_cnt_o, bus.credit_err_o); end
    bus.net_credit_i = 1'b1;
    tick();
    bus.net_credit_i = 1'b0;
    n_cmp++; if (bus.credit_cnt_o !== 3'd4) begin n_err++; $display("FAIL corner_saturate got %0d want 4", bus.credit_cnt_o); end
    n_cmp++; if (bus.credit_err_o !== 1'b1) begin n_err++; $display("FAIL corner_err got %b want 1", bus.credit_err_o); end
    tick();
    n_cmp++; if (bus.credit_err_o !== 1'b1) begin n_err++; $display("FAIL corner_err_sticky got %b want 1", bus.credit_err_o); end
  endtask

  task automatic test_rx_overflow();
    logic [15:0] exp_d;
    for (int k = 0; k < 4; k++) begin
      bus.net_enable_i = 1'b1;
      bus.net_data_i   = 16'hA001 + 16'(k);
      tick();
    end
    bus.net_enable_i = 1'b0;
    n_cmp++; if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 16'hA001)
      begin n_err++; $display("FAIL ovf_head got v=%b d=%h want 1/A001", bus.rx_valid_o, bus.rx_data_o); end
    n_cmp++; if (bus.rx_overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", bus.rx_overflow_o); end
    bus.net_enable_i = 1'b1;
    bus.net_data_i   = 16'hA005;
    tick();
    bus.net_enable_i = 1'b0;
    n_cmp++; if (bus.rx_overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", bus.rx_overflow_o); end
    for (int k = 0; k < 4; k++) begin
      exp_d = 16'hA001 + 16'(k);
      n_cmp++; if (bus.rx_data_o !== exp_d) begin n_err++; $display("FAIL ovf_pop_data[%0d] got %h want %h", k, bus.rx_data_o, exp_d); end
      n_cmp++; if (bus.net_credit_o !== 1'b0) begin n_err++; $display("FAIL ovf_credit_before[%0d] got %b want 0", k, bus.net_credit_o); end
      bus.rx_pop_i = 1'b1;
      tick();
      bus.rx_pop_i = 1'b0;
      n_cmp++; if (bus.net_credit_o !== 1'b1) begin n_err++; $display("FAIL ovf_credit[%0d] got %b want 1", k, bus.net_credit_o); end
      n_cmp++; if (bus.rx_count_o !== 16'(k + 1)) begin n_err++; $display("FAIL ovf_rx_count[%0d] got %0d want %0d", k, bus.rx_count_o, k + 1); end
      tick();
    end
    n_cmp++; if (bus.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL ovf_drained got %b want 0", bus.rx_valid_o); end
    bus.rx_pop_i = 1'b1;
    tick();
    bus.rx_pop_i = 1'b0;
    n_cmp++; if (bus.net_credit_o !== 1'b0 || bus.rx_count_o !== 16'd4)
      begin n_err++; $display("FAIL empty_pop got credit=%b count=%0d want 0/4", bus.net_credit_o, bus.rx_count_o); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_q [4] = '{16'hC002, 16'hC003, 16'hC004, 16'hB0B0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.net_enable_i = 1'b1;
      bus.net_data_i   = 16'hC001 + 16'(k);
      tick();
    end
    bus.net_data_i = 16'hB0B0;
    bus.rx_pop_i   = 1'b1;
    #1;
    n_cmp++; if (bus.rx_data_o !== 16'hC001) begin n_err++; $display("FAIL full_head got %h want C001", bus.rx_data_o); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.rx_overflow_o !== 1'b0) begin n_err++; $display("FAIL full_no_ovf got %b want 0", bus.rx_overflow_o); end
    n_cmp++; if (bus.rx_count_o !== 16'd1 || bus.net_credit_o !== 1'b1)
      begin n_err++; $display("FAIL full_pop got count=%0d credit=%b want 1/1", bus.rx_count_o, bus.net_credit_o); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.rx_data_o !== exp_q[k]) begin n_err++; $display("FAIL full_order[%0d] got %h want %h", k, bus.rx_data_o, exp_q[k]); end
      bus.rx_pop_i = 1'b1;
      tick();
      bus.rx_pop_i = 1'b0;
    end
    n_cmp++; if (bus.rx_valid_o !== 1'b0 || bus.rx_count_o !== 16'd5)
      begin n_err++; $display("FAIL full_drain got v=%b count=%0d want 0/5", bus.rx_valid_o, bus.rx_count_o); end
    bus.net_enable_i = 1'b1;
    bus.net_data_i   = 16'hD00D;
    bus.rx_pop_i     = 1'b1;
    #1;
    n_cmp++; if (bus.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL empty_pushpop_same got %b want 0", bus.rx_valid_o); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 16'hD00D)
      begin n_err++; $display("FAIL empty_pushpop_next got v=%b d=%h want 1/D00D", bus.rx_valid_o, bus.rx_data_o); end
    n_cmp++; if (bus.rx_count_o !== 16'd5 || bus.net_credit_o !== 1'b0)
      begin n_err++; $display("FAIL empty_pushpop_nocredit got count=%0d credit=%b want 5/0", bus.rx_count_o, bus.net_credit_o); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.tx_valid_i   = 1'b1;
      bus.tx_payload_i = 8'h31 + 8'(k);
      bus.tx_dest_i    = 8'h12;
      bus.net_enable_i = (k < 2);
      bus.net_data_i   = 16'hE001 + 16'(k);
      tick();
    end
    idle_inputs();
    n_cmp++; if (bus.credit_cnt_o !== 3'd1 || bus.rx_valid_o !== 1'b1)
      begin n_err++; $display("FAIL mid_setup got cnt=%0d v=%b want 1/1", bus.credit_cnt_o, bus.rx_valid_o); end
    bus.tx_valid_i   = 1'b1;
    bus.tx_payload_i = 8'h34;
    bus.tx_dest_i    = 8'h12;
    bus.rx_pop_i     = 1'b1;
    tick();
    n_cmp++; if (bus.net_enable_o !== 1'b1 || bus.net_credit_o !== 1'b1)
      begin n_err++; $display("FAIL mid_inflight got en=%b credit=%b want 1/1", bus.net_enable_o, bus.net_credit_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.rx_valid_o !== 1'b0)      begin n_err++; $display("FAIL mid_rx_valid got %b want 0", bus.rx_valid_o); end
    n_cmp++; if (bus.credit_cnt_o !== 3'd4)    begin n_err++; $display("FAIL mid_credits got %0d want 4", bus.credit_cnt_o); end
    n_cmp++; if (bus.net_enable_o !== 1'b0 || bus.net_credit_o !== 1'b0)
      begin n_err++; $display("FAIL mid_pulses got en=%b credit=%b want 0/0", bus.net_enable_o, bus.net_credit_o); end
    n_cmp++; if (bus.tx_count_o !== 16'd0 || bus.rx_count_o !== 16'd0)
      begin n_err++; $display("FAIL mid_counts got tx=%0d rx=%0d want 0/0", bus.tx_count_o, bus.rx_count_o); end
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.rx_valid_o !== 1'b0 || bus.credit_cnt_o !== 3'd4 || bus.tx_ready_o !== 1'b1)
      begin n_err++; $display("FAIL mid_after got v=%b cnt=%0d rdy=%b want 0/4/1", bus.rx_valid_o, bus.credit_cnt_o, bus.tx_ready_o); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_tx_burst();
    test_credit_return();
    test_credit_corner();
    test_rx_overflow();
    test_full_push_pop();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
